// File: rtl/up_axi_pkg.sv
// Shared definitions for the up-to-AXI4-Lite initiator: response codes and FSM states.
package up_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WADDR = 3'd1,
    ST_RADDR = 3'd2,
    ST_WRESP = 3'd3,
    ST_RRESP = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/up_axi_master.sv
// up_axi_master: single-outstanding AXI4-Lite initiator driven by up-style register requests.
// Optional build macro UP_AXI_MASTER_TIMEOUT_EN adds a response-wait timeout; when the
// timeout fires, bready/rready stay high in IDLE to swallow one late response.
module up_axi_master
  import up_axi_pkg::*;
#(
  parameter int AXI_ADDRESS_WIDTH = 13,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                         up_clk,
  input  logic                         up_rst,
  input  logic                         up_req,
  input  logic                         up_wr,
  input  logic [AXI_ADDRESS_WIDTH-3:0] up_addr,
  input  logic [31:0]                  up_wdata,
  output logic                         up_busy,
  output logic                         up_ack,
  output logic                         up_err,
  output logic [31:0]                  up_rdata,
  output logic                         m_axi_awvalid,
  input  logic                         m_axi_awready,
  output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]                   m_axi_awprot,
  output logic                         m_axi_wvalid,
  input  logic                         m_axi_wready,
  output logic [31:0]                  m_axi_wdata,
  output logic [3:0]                   m_axi_wstrb,
  input  logic                         m_axi_bvalid,
  output logic                         m_axi_bready,
  input  logic [1:0]                   m_axi_bresp,
  output logic                         m_axi_arvalid,
  input  logic                         m_axi_arready,
  output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]                   m_axi_arprot,
  input  logic                         m_axi_rvalid,
  output logic                         m_axi_rready,
  input  logic [31:0]                  m_axi_rdata,
  input  logic [1:0]                   m_axi_rresp
);

  localparam int WA_W = AXI_ADDRESS_WIDTH - 2;

  state_t            state_q,   state_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q,  wvalid_d;
  logic              arvalid_q, arvalid_d;
  logic              bready_q,  bready_d;
  logic              rready_q,  rready_d;
  logic [WA_W-1:0]   addr_q,    addr_d;
  logic [31:0]       wdata_q,   wdata_d;
  logic [31:0]       rdata_q,   rdata_d;
  logic              busy_q,    busy_d;
  logic              ack_q,     ack_d;
  logic              err_q,     err_d;

`ifdef UP_AXI_MASTER_TIMEOUT_EN
  localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic              swallow_q, swallow_d;
`else
  // The timeout length only matters when the timeout build is selected.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Next-state and next-output logic for the single-transaction FSM.
  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = bready_q;
    rready_d  = rready_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    busy_d    = busy_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
`ifdef UP_AXI_MASTER_TIMEOUT_EN
    cnt_d     = cnt_q;
    swallow_d = swallow_q;
    // A late response after a timeout is accepted once and then dropped on the floor.
    if (swallow_q && ((bready_q && m_axi_bvalid) || (rready_q && m_axi_rvalid))) begin
      bready_d  = 1'b0;
      rready_d  = 1'b0;
      swallow_d = 1'b0;
    end
`endif
    case (state_q)
      ST_IDLE: begin
        if (up_req) begin
          addr_d = up_addr;
          busy_d = 1'b1;
`ifdef UP_AXI_MASTER_TIMEOUT_EN
          bready_d  = 1'b0;
          rready_d  = 1'b0;
          swallow_d = 1'b0;
`endif
          if (up_wr) begin
            wdata_d   = up_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WADDR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RADDR;
          end
        end
      end
      ST_WADDR: begin
        // Address and data channels complete independently, in either order.
        awvalid_d = awvalid_q & ~m_axi_awready;
        wvalid_d  = wvalid_q  & ~m_axi_wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_WRESP;
`ifdef UP_AXI_MASTER_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      ST_WRESP: begin
        if (m_axi_bvalid) begin
          bready_d = 1'b0;
          ack_d    = 1'b1;
          err_d    = (m_axi_bresp != AXI_RESP_OKAY);
          state_d  = ST_DONE;
        end
`ifdef UP_AXI_MASTER_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          rready_d  = 1'b1;
          swallow_d = 1'b1;
          ack_d     = 1'b1;
          err_d     = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_RADDR: begin
        arvalid_d = arvalid_q & ~m_axi_arready;
        if (!arvalid_d) begin
          rready_d = 1'b1;
          state_d  = ST_RRESP;
`ifdef UP_AXI_MASTER_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      ST_RRESP: begin
        if (m_axi_rvalid) begin
          rready_d = 1'b0;
          rdata_d  = m_axi_rdata;
          ack_d    = 1'b1;
          err_d    = (m_axi_rresp != AXI_RESP_OKAY);
          state_d  = ST_DONE;
        end
`ifdef UP_AXI_MASTER_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          bready_d  = 1'b1;
          swallow_d = 1'b1;
          ack_d     = 1'b1;
          err_d     = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears every valid/ready immediately.
  always_ff @(posedge up_clk or posedge up_rst) begin
    if (up_rst) begin
      state_q   <= ST_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
`ifdef UP_AXI_MASTER_TIMEOUT_EN
      cnt_q     <= '0;
      swallow_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
`ifdef UP_AXI_MASTER_TIMEOUT_EN
      cnt_q     <= cnt_d;
      swallow_q <= swallow_d;
`endif
    end
  end

  assign up_busy       = busy_q;
  assign up_ack        = ack_q;
  assign up_err        = err_q;
  assign up_rdata      = rdata_q;

  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = {addr_q, 2'b00};
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hf;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = {addr_q, 2'b00};
  assign m_axi_arprot  = 3'b000;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_up_axi_master.sv
// Testbench for up_axi_master: AXI4-Lite slave responder with programmable delays,
// channel monitor, and a transaction-level reference model.
module tb_up_axi_master;

  localparam int AW = 13;
  localparam int TO = 16;
`ifdef UP_AXI_MASTER_TIMEOUT_EN
  localparam bit TIMEOUT_BUILD = 1'b1;
`else
  localparam bit TIMEOUT_BUILD = 1'b0;
`endif

  logic          up_clk = 1'b0;
  logic          up_rst;
  logic          up_req;
  logic          up_wr;
  logic [AW-3:0] up_addr;
  logic [31:0]   up_wdata;
  logic          up_busy, up_ack, up_err;
  logic [31:0]   up_rdata;
  logic          m_axi_awvalid, m_axi_awready;
  logic [AW-1:0] m_axi_awaddr;
  logic [2:0]    m_axi_awprot;
  logic          m_axi_wvalid, m_axi_wready;
  logic [31:0]   m_axi_wdata;
  logic [3:0]    m_axi_wstrb;
  logic          m_axi_bvalid, m_axi_bready;
  logic [1:0]    m_axi_bresp;
  logic          m_axi_arvalid, m_axi_arready;
  logic [AW-1:0] m_axi_araddr;
  logic [2:0]    m_axi_arprot;
  logic          m_axi_rvalid, m_axi_rready;
  logic [31:0]   m_axi_rdata;
  logic [1:0]    m_axi_rresp;

  always #5 up_clk = ~up_clk;

  up_axi_master #(.AXI_ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .up_clk(up_clk), .up_rst(up_rst), .up_req(up_req), .up_wr(up_wr),
    .up_addr(up_addr), .up_wdata(up_wdata), .up_busy(up_busy), .up_ack(up_ack),
    .up_err(up_err), .up_rdata(up_rdata),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp)
  );

  int errors = 0;
  int checks = 0;

  // responder configuration
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;

  // monitor results
  logic [AW-1:0] aw_q[$];
  logic [AW-1:0] ar_q[$];
  logic [31:0]   w_q[$];
  int cyc = 0, ack_total = 0, ack_cyc = 0, b_count = 0, r_count = 0;
  int aw_fire_cyc = 0, w_fire_cyc = 0, bready_rise_cyc = 0, viol = 0;

  // responder private state
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  bit b_pend = 0, r_pend = 0, aw_done_w = 0, w_done_w = 0;
  bit f_aw = 0, f_w = 0, f_ar = 0, f_b = 0, f_r = 0;
  bit p_awv = 0, p_wv = 0, p_arv = 0, p_bready = 0;
  logic [AW-1:0] p_awaddr = '0, p_araddr = '0;
  logic [31:0]   p_wdata = '0;

  // AXI4-Lite slave + protocol monitor, evaluated once per cycle on the falling edge
  initial begin
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0;
    forever begin
      @(negedge up_clk);
      cyc++;
      if (up_rst) begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_rvalid = 0;
        b_pend = 0; r_pend = 0; aw_done_w = 0; w_done_w = 0;
        f_aw = 0; f_w = 0; f_ar = 0; f_b = 0; f_r = 0;
        p_awv = 0; p_wv = 0; p_arv = 0; p_bready = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        continue;
      end
      // a valid must hold, with stable payload, until its handshake
      if (p_awv && !f_aw && (!m_axi_awvalid || m_axi_awaddr != p_awaddr)) viol++;
      if (p_wv  && !f_w  && (!m_axi_wvalid  || m_axi_wdata  != p_wdata))  viol++;
      if (p_arv && !f_ar && (!m_axi_arvalid || m_axi_araddr != p_araddr)) viol++;
      if (m_axi_wvalid && m_axi_wstrb != 4'hf) viol++;
      if ((m_axi_awvalid && m_axi_awprot != 3'b000) || (m_axi_arvalid && m_axi_arprot != 3'b000)) viol++;
      // retire handshakes completed at the last rising edge
      if (f_aw) aw_done_w = 1;
      if (f_w)  w_done_w = 1;
      if (aw_done_w && w_done_w) begin b_pend = 1; b_cnt = 0; aw_done_w = 0; w_done_w = 0; end
      if (f_ar) begin r_pend = 1; r_cnt = 0; end
      if (f_b) begin m_axi_bvalid = 0; b_count++; end
      if (f_r) begin m_axi_rvalid = 0; r_count++; end
      // address/data readies after the programmed delay
      if (m_axi_awvalid) begin
        if (aw_cnt >= aw_delay) m_axi_awready = 1; else begin m_axi_awready = 0; aw_cnt++; end
      end else begin m_axi_awready = 0; aw_cnt = 0; end
      if (m_axi_wvalid) begin
        if (w_cnt >= w_delay) m_axi_wready = 1; else begin m_axi_wready = 0; w_cnt++; end
      end else begin m_axi_wready = 0; w_cnt = 0; end
      if (m_axi_arvalid) begin
        if (ar_cnt >= ar_delay) m_axi_arready = 1; else begin m_axi_arready = 0; ar_cnt++; end
      end else begin m_axi_arready = 0; ar_cnt = 0; end
      // responses after the programmed delay
      if (b_pend && !m_axi_bvalid) begin
        if (b_cnt >= b_delay) begin m_axi_bvalid = 1; m_axi_bresp = bresp_cfg; b_pend = 0; end
        else b_cnt++;
      end
      if (r_pend && !m_axi_rvalid) begin
        if (r_cnt >= r_delay) begin
          m_axi_rvalid = 1; m_axi_rresp = rresp_cfg; m_axi_rdata = rdata_cfg; r_pend = 0;
        end else r_cnt++;
      end
      // handshakes that will complete at the next rising edge
      f_aw = m_axi_awvalid && m_axi_awready;
      f_w  = m_axi_wvalid  && m_axi_wready;
      f_ar = m_axi_arvalid && m_axi_arready;
      f_b  = m_axi_bvalid  && m_axi_bready;
      f_r  = m_axi_rvalid  && m_axi_rready;
      if (f_aw) begin aw_q.push_back(m_axi_awaddr); aw_fire_cyc = cyc; end
      if (f_w)  begin w_q.push_back(m_axi_wdata);   w_fire_cyc = cyc; end
      if (f_ar) ar_q.push_back(m_axi_araddr);
      p_awv = m_axi_awvalid; p_awaddr = m_axi_awaddr;
      p_wv  = m_axi_wvalid;  p_wdata  = m_axi_wdata;
      p_arv = m_axi_arvalid; p_araddr = m_axi_araddr;
      if (up_ack) begin ack_total++; ack_cyc = cyc; end
      if (m_axi_bready && !p_bready) bready_rise_cyc = cyc;
      p_bready = m_axi_bready;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge up_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model state: up_rdata as the specification defines it
  logic [31:0] rd_model = 32'h0;

  // one request; expected results derived from the transaction description alone
  task automatic do_txn(input string tag, input bit wr, input logic [AW-3:0] addr,
                        input logic [31:0] wdata, input logic [1:0] resp,
                        input logic [31:0] rdat, input int dly);
    int acks0 = ack_total;
    int awn = aw_q.size(), wn = w_q.size(), arn = ar_q.size();
    int n = 0;
    bit timed_out = TIMEOUT_BUILD && (dly >= TO);
    bit exp_err = timed_out || (resp != 2'b00);
    bresp_cfg = resp; rresp_cfg = resp; rdata_cfg = rdat; b_delay = dly; r_delay = dly;
    if (!wr && !timed_out) rd_model = rdat;
    up_req = 1; up_wr = wr; up_addr = addr; up_wdata = wdata;
    tick();
    up_req = 0; up_addr = AW'($urandom) >> 2; up_wdata = $urandom;
    chk({tag, "_busy"}, {31'b0, up_busy}, 32'd1);
    while (!up_ack && n < 200) begin tick(); n++; end
    chk({tag, "_ack"}, {31'b0, up_ack}, 32'd1);
    chk({tag, "_err"}, {31'b0, up_err}, {31'b0, exp_err});
    chk({tag, "_rdata"}, up_rdata, rd_model);
    tick();
    chk({tag, "_ack_pulse_busy"}, {30'b0, up_ack, up_busy}, 32'd0);
    chk({tag, "_acks"}, ack_total, acks0 + 1);
    if (wr) begin
      chk({tag, "_chan_cnt"}, {aw_q.size() - awn, w_q.size() - wn, ar_q.size() - arn}, {32'd1, 32'd1, 32'd0});
      if (aw_q.size() > awn) chk({tag, "_awaddr"}, 32'(aw_q[$]), 32'(addr) << 2);
      if (w_q.size() > wn)   chk({tag, "_wdata"}, w_q[$], wdata);
    end else begin
      chk({tag, "_chan_cnt"}, {aw_q.size() - awn, w_q.size() - wn, ar_q.size() - arn}, {32'd0, 32'd0, 32'd1});
      if (ar_q.size() > arn) chk({tag, "_araddr"}, 32'(ar_q[$]), 32'(addr) << 2);
    end
  endtask

  bit            wr_a[20];
  logic [AW-3:0] ad_a[20];
  logic [31:0]   d_a[20];

  initial begin
    int acks0, awn, wn, arn, b0, n, nw, nr, ai, wi, ri;
    up_rst = 1; up_req = 0; up_wr = 0; up_addr = '0; up_wdata = '0;
    tick(); tick();
    // reset state
    chk("rst_ctrl", {24'b0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                     m_axi_rready, up_busy, up_ack, up_err}, 32'd0);
    chk("rst_rdata", up_rdata, 32'd0);
    chk("rst_addr_data", {m_axi_awaddr, m_axi_araddr, 6'b0} | m_axi_wdata, 32'd0);
    chk("rst_const", {25'b0, m_axi_wstrb, m_axi_awprot | m_axi_arprot}, 32'h78);
    up_rst = 0;
    tick(); tick();

    // 1: write with late awready, immediate wready
    aw_delay = 3; w_delay = 0;
    do_txn("t1_wr", 1'b1, 11'h040, 32'h12345678, 2'b00, 32'h0, 0);
    chk("t1_awaddr_0x100", 32'(aw_q[$]), 32'h100);
    chk("t1_w_before_aw", 32'(w_fire_cyc < aw_fire_cyc), 32'd1);
    aw_delay = 0;

    // 2: plain read
    do_txn("t2_rd", 1'b0, 11'h001, 32'h0, 2'b00, 32'hCAFEF00D, 0);
    chk("t2_araddr_0x004", 32'(ar_q[$]), 32'h004);
    chk("t2_rdata", up_rdata, 32'hCAFEF00D);

    // 3: error responses
    do_txn("t3_rd_slverr", 1'b0, 11'h2A5, 32'h0, 2'b10, 32'h0BADC0DE, 1);
    do_txn("t3_wr_decerr", 1'b1, 11'h7FF, 32'hDEADBEEF, 2'b11, 32'h0, 2);

    // randomized transactions with random channel delays
    for (int k = 0; k < 12; k++) begin
      aw_delay = $urandom_range(0, 4); w_delay = $urandom_range(0, 4); ar_delay = $urandom_range(0, 4);
      do_txn("rnd", 1'($urandom_range(0, 1)), 11'($urandom), $urandom,
             2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 6));
    end
    aw_delay = 0; w_delay = 0; ar_delay = 0;

    // 4: request held every cycle; one transaction per 4-cycle turnaround
    b_delay = 0; r_delay = 0; bresp_cfg = 2'b00; rresp_cfg = 2'b00; rdata_cfg = 32'h600DF00D;
    acks0 = ack_total; awn = aw_q.size(); wn = w_q.size(); arn = ar_q.size();
    for (int i = 0; i < 20; i++) begin
      wr_a[i] = 1'($urandom_range(0, 1)); ad_a[i] = 11'($urandom); d_a[i] = $urandom;
    end
    for (int i = 0; i < 20; i++) begin
      up_req = 1; up_wr = wr_a[i]; up_addr = ad_a[i]; up_wdata = d_a[i];
      tick();
    end
    up_req = 0;
    repeat (6) tick();
    nw = 0; nr = 0;
    for (int i = 0; i < 20; i += 4) if (wr_a[i]) nw++; else nr++;
    chk("t4_acks", ack_total - acks0, 32'd5);
    chk("t4_chan_cnt", {aw_q.size() - awn, w_q.size() - wn, ar_q.size() - arn}, {nw, nw, nr});
    ai = awn; wi = wn; ri = arn;
    for (int i = 0; i < 20; i += 4) begin
      if (wr_a[i]) begin
        if (ai < aw_q.size()) chk("t4_awaddr", 32'(aw_q[ai]), 32'(ad_a[i]) << 2);
        if (wi < w_q.size())  chk("t4_wdata", w_q[wi], d_a[i]);
        ai++; wi++;
      end else begin
        if (ri < ar_q.size()) chk("t4_araddr", 32'(ar_q[ri]), 32'(ad_a[i]) << 2);
        ri++;
        rd_model = rdata_cfg;
      end
    end
    chk("t4_rdata", up_rdata, rd_model);

`ifdef UP_AXI_MASTER_TIMEOUT_EN
    // 5: write response never arrives in time; late response is swallowed
    b0 = b_count;
    do_txn("t5_wr_timeout", 1'b1, 11'h123, 32'hA5A5A5A5, 2'b00, 32'h0, 20);
    chk("t5_latency", ack_cyc - bready_rise_cyc, TO);
    acks0 = ack_total;
    n = 0;
    while (b_count == b0 && n < 40) begin tick(); n++; end
    chk("t5_late_absorbed", b_count, b0 + 1);
    tick();
    chk("t5_readies_low", {30'b0, m_axi_bready, m_axi_rready}, 32'd0);
    chk("t5_no_extra_ack", ack_total, acks0);
    do_txn("t5_rd_after", 1'b0, 11'h0F0, 32'h0, 2'b00, 32'h13579BDF, 2);
`endif

    // 6: reset while waiting for a read response
    ar_delay = 0; r_delay = 8; rresp_cfg = 2'b00; rdata_cfg = 32'hFFFF0000;
    up_req = 1; up_wr = 0; up_addr = 11'h155;
    tick();
    up_req = 0;
    n = 0;
    while (!m_axi_rready && n < 20) begin tick(); n++; end
    chk("t6_rready_seen", {31'b0, m_axi_rready}, 32'd1);
    acks0 = ack_total;
    #2 up_rst = 1;
    #1;
    chk("t6_low_async", {28'b0, m_axi_arvalid, m_axi_rready, up_busy, up_ack}, 32'd0);
    tick(); tick(); tick();
    up_rst = 0;
    rd_model = 32'h0;
    repeat (12) tick();
    chk("t6_no_ack", ack_total, acks0);
    chk("t6_rdata_cleared", up_rdata, 32'd0);
    do_txn("t6_wr_after", 1'b1, 11'h3C3, 32'h0F1E2D3C, 2'b00, 32'h0, 1);

    chk("protocol_violations", viol, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
